// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg
//   Shared constants and types for the debug register reader.
//   XLEN      : register / PC width
//   NREGS     : number of architectural integer registers
//   REG_IDX_W : register index width
//   dbg_rd_state_e : reader FSM state encoding
// ---------------------------------------------------------------------------
package dbg_pkg;

  localparam int XLEN      = 64;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DUMP = 2'd2
  } dbg_rd_state_e;

endpackage

// File: rtl/dbg_shadow_rf.sv
// ---------------------------------------------------------------------------
// dbg_shadow_rf
//   Shadow copy of the integer register file, fed from the writeback stream.
//   Each entry carries the value and the PC of the instruction that last
//   wrote it. One write port, one combinational read port.
//
//   clk, rst_n : clock, asynchronous active-low reset (clears data and tags)
//   we         : write strobe
//   waddr      : write index (index 0 is never stored)
//   wdata, wpc : value and writer PC
//   raddr      : read index
//   rdata, rpc : read value and writer PC; write-first bypass, x0 reads 0
// ---------------------------------------------------------------------------
module dbg_shadow_rf
  import dbg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      wpc,
  input  logic [REG_IDX_W-1:0] raddr,
  output logic [XLEN-1:0]      rdata,
  output logic [XLEN-1:0]      rpc
);

  logic [XLEN-1:0] data_q [NREGS];
  logic [XLEN-1:0] tag_q  [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (we && (waddr != '0)) begin
      data_q[waddr] <= wdata;
      tag_q[waddr]  <= wpc;
    end
  end

  // A write landing on the index being read this cycle is returned directly,
  // so a launch in the same cycle as the writeback sees the new value and PC.
  always_comb begin
    rdata = '0;
    rpc   = '0;
    if (raddr != '0) begin
      if (we && (waddr == raddr)) begin
        rdata = wdata;
        rpc   = wpc;
      end else begin
        rdata = data_q[raddr];
        rpc   = tag_q[raddr];
      end
    end
  end

endmodule

// File: rtl/dbg_reg_reader.sv
// ---------------------------------------------------------------------------
// dbg_reg_reader
//   Debugger-facing reader of a shadow register file that snoops the integer
//   writeback stream. Serves single-register reads or a full register dump
//   over a valid/ready request/response interface.
//
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb_valid/pc/rd/data   : writeback snoop stream
//   req_valid/req_ready   : single-register read request handshake
//   req_idx               : register to read
//   dump_start            : pulse, dump all registers (only honoured in IDLE)
//   resp_valid/resp_ready : response handshake; payload held until consumed
//   resp_idx/data/pc      : response payload (pc 0 = never written)
//   dump_done             : one-cycle pulse after the last dump beat is taken
// ---------------------------------------------------------------------------
module dbg_reg_reader
  import dbg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic [XLEN-1:0]      wb_pc,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_IDX_W-1:0] req_idx,
  input  logic                 dump_start,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_IDX_W-1:0] resp_idx,
  output logic [XLEN-1:0]      resp_data,
  output logic [XLEN-1:0]      resp_pc,
  output logic                 dump_done
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NREGS - 1);

  dbg_rd_state_e        state;
  dbg_rd_state_e        state_nxt;
  logic [REG_IDX_W-1:0] beat;

  logic                 launch_req;
  logic                 launch_beat;
  logic                 launch;
  logic                 resp_fire;
  logic                 last_fire;
  logic [REG_IDX_W-1:0] rd_idx;
  logic [XLEN-1:0]      rf_data;
  logic [XLEN-1:0]      rf_pc;

  // Snooping is unconditional: the shadow tracks writeback in every state.
  dbg_shadow_rf u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wb_valid),
    .waddr (wb_rd),
    .wdata (wb_data),
    .wpc   (wb_pc),
    .raddr (rd_idx),
    .rdata (rf_data),
    .rpc   (rf_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nxt = DUMP;
        end else if (req_valid) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_fire) begin
          state_nxt = IDLE;
        end
      end
      DUMP: begin
        if (last_fire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Dump beats are launched whenever no beat is outstanding; since the
  // consuming cycle clears resp_valid, the next beat follows one cycle later.
  always_comb begin
    req_ready   = (state == IDLE) && !dump_start;
    launch_req  = req_ready && req_valid;
    launch_beat = (state == DUMP) && !resp_valid;
    launch      = launch_req || launch_beat;
    resp_fire   = resp_valid && resp_ready;
    last_fire   = (state == DUMP) && resp_fire && (beat == LAST_IDX);
    rd_idx      = (state == DUMP) ? beat : req_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if ((state == IDLE) && dump_start) begin
      beat <= '0;
    end else if ((state == DUMP) && resp_fire && !last_fire) begin
      beat <= beat + REG_IDX_W'(1);
    end
  end

  // Payload is captured only at launch, so later writes to the same register
  // cannot disturb a response that is waiting on backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_idx   <= '0;
      resp_data  <= '0;
      resp_pc    <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= last_fire;
      if (launch) begin
        resp_valid <= 1'b1;
        resp_idx   <= rd_idx;
        resp_data  <= rf_data;
        resp_pc    <= rf_pc;
      end else if (resp_fire) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dbg_reg_reader.sv
module tb_dbg_reg_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [63:0] wb_pc;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_idx;
  logic        dump_start;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_idx;
  logic [63:0] resp_data;
  logic [63:0] resp_pc;
  logic        dump_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    bit          pre_wr;
    bit          same_wr;
    logic [4:0]  wr_rd;
    logic [63:0] wr_data;
    logic [63:0] wr_pc;
    logic [4:0]  rd_idx;
    logic [63:0] exp_data;
    logic [63:0] exp_pc;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [63:0] mdl_data[32];
  logic [63:0] mdl_pc[32];

  always #5 clk = ~clk;

  dbg_reg_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .dump_start (dump_start),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_idx   (resp_idx),
    .resp_data  (resp_data),
    .resp_pc    (resp_pc),
    .dump_done  (dump_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mdl_write(input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
    if (rd != 5'd0) begin
      mdl_data[rd] = d;
      mdl_pc[rd]   = pc;
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) begin
      mdl_data[i] = '0;
      mdl_pc[i]   = '0;
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_resp: got idx %0d with empty scoreboard, required none", resp_idx);
    end else begin
      e = sb.pop_front();
      check("resp_idx", 64'(resp_idx), 64'(e.idx));
      check("resp_data", resp_data, e.data);
      check("resp_pc", resp_pc, e.pc);
    end
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    wb_pc    = pc;
    step();
    wb_valid = 1'b0;
    mdl_write(rd, d, pc);
  endtask

  task automatic wait_resp(input int bound);
    bit got = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < bound && !got; i++) begin
      if (resp_valid) begin
        pop_compare();
        got = 1;
      end
      step();
    end
    resp_ready = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: got no response in %0d cycles, required one", bound);
    end
  endtask

  task automatic do_read(input logic [4:0] idx, input bit same_wr, input logic [4:0] rd,
                         input logic [63:0] d, input logic [63:0] pc,
                         input logic [63:0] exp_d, input logic [63:0] exp_pc);
    exp_t e;
    req_valid = 1'b1;
    req_idx   = idx;
    if (same_wr) begin
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
      wb_pc    = pc;
    end
    #1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    e.idx  = idx;
    e.data = exp_d;
    e.pc   = exp_pc;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    wb_valid  = 1'b0;
    if (same_wr) mdl_write(rd, d, pc);
    check("resp_latency", 64'(resp_valid), 64'd1);
    wait_resp(20);
  endtask

  task automatic push_dump_expect();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.idx  = 5'(i);
      e.data = mdl_data[i];
      e.pc   = mdl_pc[i];
      sb.push_back(e);
    end
  endtask

  initial begin
    int   beats;
    int   cyc;
    bit   hit;
    exp_t e;

    rst_n      = 1'b0;
    wb_valid   = 1'b0;
    wb_pc      = '0;
    wb_rd      = '0;
    wb_data    = '0;
    req_valid  = 1'b0;
    req_idx    = '0;
    dump_start = 1'b0;
    resp_ready = 1'b0;
    mdl_clear();

    //                pre  same rd     wr_data                wr_pc         rd_idx exp_data               exp_pc
    vecs[0] = '{1'b0, 1'b0, 5'd0,  64'h0,                 64'h0,        5'd5,  64'h0,                 64'h0};
    vecs[1] = '{1'b1, 1'b0, 5'd10, 64'hDEAD,              64'h80000010, 5'd10, 64'hDEAD,              64'h80000010};
    vecs[2] = '{1'b1, 1'b0, 5'd0,  64'h1234,              64'h80000020, 5'd0,  64'h0,                 64'h0};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  64'h55,                64'h100,      5'd7,  64'h55,                64'h100};
    vecs[4] = '{1'b0, 1'b0, 5'd0,  64'h0,                 64'h0,        5'd10, 64'hDEAD,              64'h80000010};
    vecs[5] = '{1'b1, 1'b0, 5'd31, 64'hFFFFFFFFFFFFFFFF,  64'h200,      5'd31, 64'hFFFFFFFFFFFFFFFF,  64'h200};
    vecs[6] = '{1'b0, 1'b1, 5'd3,  64'hAB,                64'h300,      5'd4,  64'h0,                 64'h0};
    vecs[7] = '{1'b0, 1'b0, 5'd0,  64'h0,                 64'h0,        5'd3,  64'hAB,                64'h300};

    @(negedge clk);
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_idx", 64'(resp_idx), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_pc", resp_pc, 64'd0);
    check("rst_dump_done", 64'(dump_done), 64'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].pre_wr) wb_write(vecs[v].wr_rd, vecs[v].wr_data, vecs[v].wr_pc);
      do_read(vecs[v].rd_idx, vecs[v].same_wr, vecs[v].wr_rd, vecs[v].wr_data,
              vecs[v].wr_pc, vecs[v].exp_data, vecs[v].exp_pc);
    end

    // Bypass on launch, then hold under backpressure while x7 is rewritten.
    req_valid = 1'b1;
    req_idx   = 5'd7;
    wb_valid  = 1'b1;
    wb_rd     = 5'd7;
    wb_data   = 64'h55;
    wb_pc     = 64'h400;
    e.idx = 5'd7; e.data = 64'h55; e.pc = 64'h400;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    mdl_write(5'd7, 64'h55, 64'h400);
    for (int k = 0; k < 5; k++) begin
      wb_valid = 1'b1;
      wb_rd    = 5'd7;
      wb_data  = 64'h66;
      wb_pc    = 64'h500;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", resp_data, 64'h55);
      check("hold_pc", resp_pc, 64'h400);
      step();
    end
    wb_valid = 1'b0;
    mdl_write(5'd7, 64'h66, 64'h500);
    wait_resp(20);
    do_read(5'd7, 1'b0, 5'd0, 64'h0, 64'h0, 64'h66, 64'h500);

    // Dump wins over a simultaneous request; random backpressure.
    dump_start = 1'b1;
    req_valid  = 1'b1;
    req_idx    = 5'd5;
    #1;
    check("dump_req_ready", 64'(req_ready), 64'd0);
    push_dump_expect();
    step();
    dump_start = 1'b0;
    req_valid  = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 32 && cyc < 2000) begin
      resp_ready = 1'($urandom_range(0, 1));
      check("dump_busy_ready", 64'(req_ready), 64'd0);
      check("dump_done_early", 64'(dump_done), 64'd0);
      if (resp_valid && resp_ready) begin
        pop_compare();
        beats++;
      end
      step();
      cyc++;
    end
    resp_ready = 1'b0;
    check("dump_beats", 64'(beats), 64'd32);
    check("dump_done_pulse", 64'(dump_done), 64'd1);
    step();
    check("dump_done_clear", 64'(dump_done), 64'd0);
    check("post_dump_ready", 64'(req_ready), 64'd1);
    check("post_dump_sb_empty", 64'(sb.size()), 64'd0);
    check("post_dump_resp_valid", 64'(resp_valid), 64'd0);

    // Reset in the middle of a dump at beat 12.
    dump_start = 1'b1;
    push_dump_expect();
    step();
    dump_start = 1'b0;
    resp_ready = 1'b1;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < 500) begin
      if (resp_valid && resp_idx == 5'd12) begin
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_resp_idx", 64'(resp_idx), 64'd0);
        check("abort_dump_done", 64'(dump_done), 64'd0);
        hit = 1;
      end else begin
        if (resp_valid) pop_compare();
        step();
        cyc++;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL abort_beat12: got no beat 12 within %0d cycles, required one", cyc);
    end
    sb.delete();
    mdl_clear();
    resp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_done", 64'(dump_done), 64'd0);
    end
    check("abort_idle_ready", 64'(req_ready), 64'd1);
    check("abort_idle_valid", 64'(resp_valid), 64'd0);
    do_read(5'd10, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
